// File: rtl/addr_cmd_issuer_if.sv
// Command-address bus bundle: host-side command handshake plus decoder-facing outputs.
interface addr_cmd_issuer_if #(
  parameter int ADDR_W = 5
);
  logic              cmd_valid;
  logic [ADDR_W-1:0] cmd_code;
  logic              cmd_ready;
  logic [ADDR_W-1:0] addr;
  logic              issued;
  logic              drop;
  logic              busy;

  modport master (
    output cmd_valid, cmd_code,
    input  cmd_ready, addr, issued, drop, busy
  );

  modport slave (
    input  cmd_valid, cmd_code,
    output cmd_ready, addr, issued, drop, busy
  );
endinterface

// File: rtl/addr_cmd_issuer.sv
// Queues command codes and drives each onto the command-address bus for a fixed hold,
// followed by an idle gap so edge-triggered decoders fire once per command.
module addr_cmd_issuer #(
  parameter int                ADDR_W      = 5,
  parameter logic [ADDR_W-1:0] IDLE_CODE   = '0,
  parameter int                HOLD_CYCLES = 2,
  parameter int                GAP_CYCLES  = 2,
  parameter int                FIFO_DEPTH  = 4
) (
  input logic              clk,
  input logic              rst_n,
  addr_cmd_issuer_if.slave bus
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  logic [ADDR_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              issued_q, drop_q;
  logic              full, empty, accept, push, pop;

  // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
  always_comb begin
    full   = (occ == OCC_W'(FIFO_DEPTH));
    empty  = (occ == '0);
    accept = bus.cmd_valid & ~full;
    push   = accept & (bus.cmd_code != IDLE_CODE);
    pop    = (state == IDLE) & ~empty;
  end

  assign bus.cmd_ready = ~full;
  assign bus.addr      = addr_q;
  assign bus.issued    = issued_q;
  assign bus.drop      = drop_q;
  assign bus.busy      = (state != IDLE) | ~empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.cmd_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= accept & (bus.cmd_code == IDLE_CODE);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= IDLE_CODE;
      issued_q <= 1'b0;
    end else begin
      issued_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            addr_q   <= mem[rd_ptr];
            issued_q <= 1'b1;
            cnt      <= CNT_W'(HOLD_CYCLES - 1);
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            addr_q <= IDLE_CODE;
            cnt    <= CNT_W'(GAP_CYCLES - 1);
            state  <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addr_cmd_issuer.sv
// Bench for addr_cmd_issuer: each accepted code gets a scheduled start time from which
// ADDR, ISSUED, BUSY and CMD_READY are predicted every cycle.
module tb_addr_cmd_issuer;
  localparam int W      = 5;
  localparam int HOLD   = 2;
  localparam int GAP    = 2;
  localparam int DEPTH  = 4;
  localparam int PERIOD = HOLD + GAP + 1;
  localparam logic [W-1:0] RST_CMD = 5'b01000;

  typedef struct {
    int         start;
    logic [W-1:0] code;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   e = 0;
  int   last_start = -1000;
  bit   exp_drop = 1'b0;
  bit   acc;
  bit   saw_ready_low;
  int   pulses = 0;
  logic [W-1:0] prev_addr = '0;
  ent_t q[$];

  addr_cmd_issuer_if #(.ADDR_W(W)) bus ();

  addr_cmd_issuer #(
    .ADDR_W(W), .IDLE_CODE(5'b00000), .HOLD_CYCLES(HOLD),
    .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Codes accepted but not yet placed on the bus.
  function automatic int m_occ();
    int n = 0;
    foreach (q[i]) if (q[i].start > e) n++;
    return n;
  endfunction

  function automatic logic [W-1:0] m_addr();
    foreach (q[i]) if (q[i].start <= e && e < q[i].start + HOLD) return q[i].code;
    return '0;
  endfunction

  function automatic bit m_issued();
    foreach (q[i]) if (q[i].start == e) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    if (m_occ() > 0) return 1'b1;
    foreach (q[i]) if (q[i].start <= e && e < q[i].start + HOLD + GAP) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic step(input bit v, input logic [W-1:0] code);
    int s;
    acc = v && (m_occ() < DEPTH);
    bus.cmd_valid = v;
    bus.cmd_code  = code;
    @(posedge clk);
    e++;
    exp_drop = acc && (code == '0);
    if (acc && code != '0) begin
      s = (last_start + PERIOD > e + 1) ? last_start + PERIOD : e + 1;
      q.push_back('{start: s, code: code});
      last_start = s;
    end
    while (q.size() > 0 && q[0].start + PERIOD + 2 < e) void'(q.pop_front());
    @(negedge clk);
    chk("ready",  32'(bus.cmd_ready), 32'(m_occ() < DEPTH));
    chk("addr",   32'(bus.addr),      32'(m_addr()));
    chk("issued", 32'(bus.issued),    32'(m_issued()));
    chk("busy",   32'(bus.busy),      32'(m_busy()));
    chk("drop",   32'(bus.drop),      32'(exp_drop));
    if (!bus.cmd_ready) saw_ready_low = 1'b1;
    if (bus.addr == RST_CMD && prev_addr != RST_CMD) pulses++;
    prev_addr = bus.addr;
    bus.cmd_valid = 1'b0;
  endtask

  // Hold the command on the bus until the model says it is taken.
  task automatic push_blocking(input logic [W-1:0] code);
    int tries = 0;
    do begin
      step(1'b1, code);
      tries++;
    end while (!acc && tries < 20);
    n_cmp++;
    assert (acc === 1'b1) else begin
      n_bad++;
      $error("FAIL push_timeout observed=%0d expected=1", acc);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = '0;
    repeat (3) @(negedge clk);
    chk("rst_addr",   32'(bus.addr),      32'd0);
    chk("rst_ready",  32'(bus.cmd_ready), 32'd1);
    chk("rst_busy",   32'(bus.busy),      32'd0);
    chk("rst_issued", 32'(bus.issued),    32'd0);
    chk("rst_drop",   32'(bus.drop),      32'd0);
    rst_n = 1'b1;

    // Single RST command: one decoder pulse.
    step(1'b1, RST_CMD);
    repeat (7) step(1'b0, '0);
    chk("single_pulses", 32'(pulses), 32'd1);

    // Same code twice: separated by a gap, two more pulses.
    step(1'b1, RST_CMD);
    step(1'b1, RST_CMD);
    repeat (12) step(1'b0, '0);
    chk("repeat_pulses", 32'(pulses), 32'd3);

    // Burst of six into a depth-four queue.
    saw_ready_low = 1'b0;
    for (int i = 0; i < 6; i++) push_blocking(W'(i + 3));
    chk("burst_full_seen", 32'(saw_ready_low), 32'd1);
    repeat (30) step(1'b0, '0);

    // Idle code is discarded.
    step(1'b1, 5'b00000);
    step(1'b1, 5'b10101);
    step(1'b1, 5'b00000);
    repeat (8) step(1'b0, '0);

    // Random stream, including full-queue refusals and idle-code drops.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 70) step(1'b1, W'($urandom_range(0, 31)));
      else                            step(1'b0, W'($urandom_range(0, 31)));
    end
    repeat (30) step(1'b0, '0);

    // Reset in the middle of a hold.
    step(1'b1, 5'b00101);
    step(1'b0, '0);
    chk("pre_rst_addr", 32'(bus.addr), 32'h05);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_addr",  32'(bus.addr),      32'd0);
    chk("midrst_busy",  32'(bus.busy),      32'd0);
    chk("midrst_ready", 32'(bus.cmd_ready), 32'd1);
    q.delete();
    last_start = -1000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_addr = bus.addr;
    step(1'b1, 5'b01001);
    repeat (10) step(1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
